// File: rtl/ula_seq_ctrl.sv
// Multi-cycle MIPS-style control sequencer for a ULA: accepts one instruction,
// decodes it, drives the ULA for one EXECUTE cycle and reports completion.
module ula_seq_ctrl (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_instr_valid,
   output logic       o_instr_ready,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   output logic [3:0] o_ula_op,
   output logic       o_src_b_imm,
   output logic       o_reg_write,
   output logic       o_branch_taken,
   output logic       o_done,
   output logic       o_illegal
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_BRANCH,
      S_ERROR
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_opcode;
   logic [5:0] r_funct;
   logic       r_zero;

   logic       w_legal;
   logic [3:0] w_op;
   logic       w_imm;
   logic       w_branch;
   logic       w_bne;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_opcode <= '0;
         r_funct  <= '0;
         r_zero   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && i_instr_valid) begin
            r_opcode <= i_opcode;
            r_funct  <= i_funct;
         end
         // Only the Z flag seen at the end of EXECUTE resolves a branch.
         if (r_state == S_EXECUTE)
            r_zero <= i_zero;
      end
   end

   always_comb begin
      w_legal  = 1'b1;
      w_op     = 4'b0000;
      w_imm    = 1'b0;
      w_branch = 1'b0;
      w_bne    = 1'b0;
      case (r_opcode)
         6'b000000: begin
            case (r_funct)
               6'b100100: w_op = 4'b0000;
               6'b100101: w_op = 4'b0001;
               6'b100000: w_op = 4'b0010;
               6'b100010: w_op = 4'b0110;
               6'b000000: w_op = 4'b0011;
               6'b000010: w_op = 4'b0100;
               6'b101010: w_op = 4'b0111;
               6'b100111: w_op = 4'b1100;
               default:   w_legal = 1'b0;
            endcase
         end
         6'b001000: begin w_op = 4'b0010; w_imm = 1'b1; end
         6'b001100: begin w_op = 4'b0000; w_imm = 1'b1; end
         6'b001101: begin w_op = 4'b0001; w_imm = 1'b1; end
         6'b001010: begin w_op = 4'b0111; w_imm = 1'b1; end
         6'b000100: begin w_op = 4'b0110; w_branch = 1'b1; end
         6'b000101: begin w_op = 4'b0110; w_branch = 1'b1; w_bne = 1'b1; end
         default:   w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (i_instr_valid) w_next = S_DECODE;
         S_DECODE:    w_next = w_legal ? S_EXECUTE : S_ERROR;
         S_EXECUTE:   w_next = w_branch ? S_BRANCH : S_WRITEBACK;
         S_WRITEBACK: w_next = S_IDLE;
         S_BRANCH:    w_next = S_IDLE;
         S_ERROR:     w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_instr_ready  = 1'b0;
      o_ula_op       = 4'b0000;
      o_src_b_imm    = 1'b0;
      o_reg_write    = 1'b0;
      o_branch_taken = 1'b0;
      o_done         = 1'b0;
      o_illegal      = 1'b0;
      case (r_state)
         S_IDLE:      o_instr_ready = 1'b1;
         S_EXECUTE: begin
            o_ula_op    = w_op;
            o_src_b_imm = w_imm;
         end
         S_WRITEBACK: begin
            o_reg_write = 1'b1;
            o_done      = 1'b1;
         end
         S_BRANCH: begin
            o_done         = 1'b1;
            o_branch_taken = w_bne ? ~r_zero : r_zero;
         end
         S_ERROR: begin
            o_illegal = 1'b1;
            o_done    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed bench for ula_seq_ctrl: a cycle-age timeline model checked every
// cycle, plus literal expectations taken straight from the instruction tables.
module tb_ula_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       ready, imm, rw, bt, done, ill;
   logic [3:0] ula_op;

   int checks = 0;
   int failures = 0;

   ula_seq_ctrl dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_instr_valid  (valid),
      .o_instr_ready  (ready),
      .i_opcode       (opcode),
      .i_funct        (funct),
      .i_zero         (zero),
      .o_ula_op       (ula_op),
      .o_src_b_imm    (imm),
      .o_reg_write    (rw),
      .o_branch_taken (bt),
      .o_done         (done),
      .o_illegal      (ill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // kind: 0 = ALU/immediate, 1 = BEQ, 2 = BNE
   typedef struct {
      logic [5:0] opc;
      logic [5:0] fn;
      bit         rtype;
      logic [3:0] op;
      bit         imm;
      int         kind;
   } ent_t;
   ent_t tbl[14];

   function automatic void lookup(input logic [5:0] o, input logic [5:0] f, output bit legal,
                                  output logic [3:0] op, output bit im, output int kind);
      legal = 0; op = '0; im = 0; kind = 0;
      foreach (tbl[i])
         if (tbl[i].opc == o && (!tbl[i].rtype || tbl[i].fn == f)) begin
            legal = 1; op = tbl[i].op; im = tbl[i].imm; kind = tbl[i].kind;
         end
   endfunction

   // Model: age counts cycles since the acceptance edge (0 = idle).
   int         m_age = 0;
   bit         m_legal = 0;
   logic [3:0] m_op = '0;
   bit         m_imm = 0;
   int         m_kind = 0;
   logic       m_z = 1'b0;
   bit         t_legal;
   logic [3:0] t_op;
   bit         t_imm;
   int         t_kind;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_age <= 0;
      end else if (m_age == 0) begin
         if (valid) begin
            lookup(opcode, funct, t_legal, t_op, t_imm, t_kind);
            m_legal <= t_legal; m_op <= t_op; m_imm <= t_imm; m_kind <= t_kind;
            m_age   <= 1;
         end
      end else begin
         if (m_age == 2 && m_legal) m_z <= zero;
         m_age <= (m_age == (m_legal ? 3 : 2)) ? 0 : m_age + 1;
      end
   end

   always @(negedge clk) begin
      logic [9:0] exp_v;
      bit fin;
      fin = m_legal ? (m_age == 3) : (m_age == 2);
      exp_v = {m_age == 0,
               (m_legal && m_age == 2) ? m_op : 4'b0000,
               m_legal && m_age == 2 && m_imm,
               m_legal && fin && m_kind == 0,
               m_legal && fin && m_kind != 0 && ((m_kind == 1) ? m_z : !m_z),
               fin && m_age != 0,
               !m_legal && fin};
      chk("cycle_outputs", {6'd0, ready, ula_op, imm, rw, bt, done, ill}, {6'd0, exp_v});
   end

   // Called at ~posedge+2 with the DUT idle.
   task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] f, input logic z,
                            input logic [3:0] e_op, input logic e_imm, input logic e_rw,
                            input logic e_bt, input logic e_ill);
      valid = 1; opcode = op; funct = f; zero = ~z;
      @(posedge clk); #2;
      valid = 0; opcode = ~op; funct = ~f;
      @(posedge clk); #2;
      zero = z; #1;
      if (!e_ill) chk({nm, "_exec"}, {11'd0, ula_op, imm}, {11'd0, e_op, e_imm});
      else        chk({nm, "_err"}, {9'd0, ula_op, done, ill, rw}, {9'd0, 4'b0000, 1'b1, 1'b1, 1'b0});
      @(posedge clk); #2;
      zero = ~z; #1;
      if (!e_ill) begin
         chk({nm, "_fin"}, {12'd0, done, rw, bt, ula_op == 4'b0000}, {12'd0, 1'b1, e_rw, e_bt, 1'b1});
         @(posedge clk); #3;
      end
      chk({nm, "_ready"}, {14'd0, ready, done}, {14'd0, 1'b1, 1'b0});
   endtask

   logic [5:0] bb_opc[12];
   logic [5:0] bb_fn[12];

   initial begin
      tbl[0]  = '{6'h00, 6'h24, 1, 4'b0000, 0, 0};
      tbl[1]  = '{6'h00, 6'h25, 1, 4'b0001, 0, 0};
      tbl[2]  = '{6'h00, 6'h20, 1, 4'b0010, 0, 0};
      tbl[3]  = '{6'h00, 6'h22, 1, 4'b0110, 0, 0};
      tbl[4]  = '{6'h00, 6'h00, 1, 4'b0011, 0, 0};
      tbl[5]  = '{6'h00, 6'h02, 1, 4'b0100, 0, 0};
      tbl[6]  = '{6'h00, 6'h2A, 1, 4'b0111, 0, 0};
      tbl[7]  = '{6'h00, 6'h27, 1, 4'b1100, 0, 0};
      tbl[8]  = '{6'h08, 6'h00, 0, 4'b0010, 1, 0};
      tbl[9]  = '{6'h0C, 6'h00, 0, 4'b0000, 1, 0};
      tbl[10] = '{6'h0D, 6'h00, 0, 4'b0001, 1, 0};
      tbl[11] = '{6'h0A, 6'h00, 0, 4'b0111, 1, 0};
      tbl[12] = '{6'h04, 6'h00, 0, 4'b0110, 0, 1};
      tbl[13] = '{6'h05, 6'h00, 0, 4'b0110, 0, 2};

      #3;
      chk("reset_state", {9'd0, ready, ula_op, imm, rw, bt, done, ill}, {9'd0, 10'b1_0000_00000});
      @(posedge clk); @(posedge clk); #2;
      rst = 0;

      run_instr("add",    6'h00, 6'h20, 1'b0, 4'b0010, 0, 1, 0, 0);
      run_instr("ori",    6'h0D, 6'h15, 1'b1, 4'b0001, 1, 1, 0, 0);
      run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 4'b0110, 0, 0, 1, 0);
      run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 4'b0110, 0, 0, 0, 0);
      run_instr("bne_z1", 6'h05, 6'h00, 1'b1, 4'b0110, 0, 0, 0, 0);
      run_instr("bne_z0", 6'h05, 6'h00, 1'b0, 4'b0110, 0, 0, 1, 0);
      run_instr("and",    6'h00, 6'h24, 1'b0, 4'b0000, 0, 1, 0, 0);
      run_instr("nor",    6'h00, 6'h27, 1'b0, 4'b1100, 0, 1, 0, 0);
      run_instr("slt",    6'h00, 6'h2A, 1'b1, 4'b0111, 0, 1, 0, 0);
      run_instr("sll",    6'h00, 6'h00, 1'b0, 4'b0011, 0, 1, 0, 0);
      run_instr("srl",    6'h00, 6'h02, 1'b0, 4'b0100, 0, 1, 0, 0);
      run_instr("slti",   6'h0A, 6'h3F, 1'b0, 4'b0111, 1, 1, 0, 0);
      run_instr("andi",   6'h0C, 6'h20, 1'b0, 4'b0000, 1, 1, 0, 0);
      run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 4'b0000, 0, 0, 0, 1);
      run_instr("ill_fn", 6'h00, 6'h08, 1'b0, 4'b0000, 0, 0, 0, 1);

      // Reset while SUB is in EXECUTE
      valid = 1; opcode = 6'h00; funct = 6'h22;
      @(posedge clk); #2;
      valid = 0;
      @(posedge clk); #3;
      chk("sub_exec", {12'd0, ula_op}, {12'd0, 4'b0110});
      rst = 1; #1;
      chk("abort_reset", {9'd0, ready, ula_op, imm, rw, bt, done, ill}, {9'd0, 10'b1_0000_00000});
      @(posedge clk); #2;
      rst = 0;
      run_instr("add_after_rst", 6'h00, 6'h20, 1'b1, 4'b0010, 0, 1, 0, 0);

      // Back-to-back with valid held and fields changing each cycle
      bb_opc = '{6'h08, 6'h3F, 6'h04, 6'h00, 6'h00, 6'h0D, 6'h05, 6'h3F,
                 6'h0D, 6'h00, 6'h0A, 6'h04};
      bb_fn  = '{6'h20, 6'h08, 6'h00, 6'h22, 6'h27, 6'h00, 6'h00, 6'h24,
                 6'h11, 6'h20, 6'h00, 6'h00};
      valid = 1;
      for (int k = 0; k < 12; k++) begin
         opcode = bb_opc[k]; funct = bb_fn[k]; zero = k[0];
         #1;
         if (k % 4 == 0) chk("b2b_ready", {15'd0, ready}, 16'd1);
         if (k == 2)  chk("b2b_addi", {11'd0, ula_op, imm}, {11'd0, 4'b0010, 1'b1});
         if (k == 6)  chk("b2b_nor",  {11'd0, ula_op, imm}, {11'd0, 4'b1100, 1'b0});
         if (k == 10) chk("b2b_ori",  {11'd0, ula_op, imm}, {11'd0, 4'b0001, 1'b1});
         @(posedge clk); #2;
      end
      valid = 0;
      repeat (3) @(posedge clk);
      #3;
      chk("final_idle", {14'd0, ready, done}, {14'd0, 1'b1, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ula_seq_ctrl.md
ULA_SEQ_CTRL -- requirements
Module: ula_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clock in 1, rising-edge; reset in 1, async active-high, forces all state and outputs to reset values immediately.
REQ-002 The block SHALL provide: instr_valid  in  1  instruction offered.
REQ-003 The block SHALL provide: instr_ready  out  1  controller can accept an instruction.
REQ-004 The block SHALL provide: opcode  in  6  MIPS opcode field, sampled at acceptance.
REQ-005 The block SHALL provide: funct  in  6  MIPS funct field, sampled at acceptance.
REQ-006 The block SHALL provide: zero  in  1  Z flag returned by the ULA.
REQ-007 The block SHALL provide: ula_op  out  4  operation select driven to the ULA OP port.
REQ-008 The block SHALL provide: src_b_imm  out  1  ULA operand B selects the immediate (1) or the register (0).
REQ-009 The block SHALL provide: reg_write  out  1  register-file write enable.
REQ-010 The block SHALL provide: branch_taken  out  1  branch resolved taken.
REQ-011 The block SHALL provide: done  out  1  one-cycle completion pulse.
REQ-012 The block SHALL provide: illegal  out  1  one-cycle pulse for an undecodable instruction.

Function
REQ-013 States SHALL be IDLE, DECODE, EXECUTE, WRITEBACK, BRANCH and ERROR; all outputs SHALL be decoded from registered state and captured fields (Moore).
REQ-014 instr_ready SHALL be 1 only in IDLE; acceptance occurs on a rising edge with instr_valid=1 in IDLE; opcode/funct SHALL be captured then; IDLE->DECODE.
REQ-015 instr_valid, opcode and funct SHALL be ignored outside IDLE; input changes after acceptance have no effect.
REQ-016 DECODE SHALL go to EXECUTE for a legal instruction and to ERROR otherwise, in one cycle.
REQ-017 R-type (opcode 000000) funct map SHALL be: 100100 AND->0000, 100101 OR->0001, 100000 ADD->0010, 100010 SUB->0110, 000000 SLL->0011, 000010 SRL->0100, 101010 SLT->0111, 100111 NOR->1100; src_b_imm=0.
REQ-018 I-type map SHALL be: 001000 ADDI->0010, 001100 ANDI->0000, 001101 ORI->0001, 001010 SLTI->0111; src_b_imm=1.
REQ-019 BEQ (000100) and BNE (000101) SHALL use 0110 (SUB) with src_b_imm=0.
REQ-020 Any other opcode, and any R-type funct not listed, SHALL be illegal.
REQ-021 ula_op and src_b_imm SHALL hold the decoded values for exactly the EXECUTE cycle, and SHALL be 0000 and 0 in every other state.
REQ-022 EXECUTE SHALL last one cycle, then go to WRITEBACK for ALU/immediate instructions and to BRANCH for BEQ/BNE.
REQ-023 zero SHALL be sampled on the edge that ends EXECUTE; only that sample determines the branch outcome.
REQ-024 WRITEBACK SHALL assert reg_write=1 and done=1 for one cycle, then go to IDLE.
REQ-025 BRANCH SHALL assert done=1 for one cycle with branch_taken equal to the sampled zero for BEQ and its inverse for BNE, then go to IDLE; reg_write SHALL be 0.
REQ-026 ERROR SHALL assert illegal=1 and done=1 for one cycle, then go to IDLE; reg_write, branch_taken and ula_op SHALL be 0.
REQ-027 Latency SHALL be fixed: done is asserted in the 3rd cycle after the acceptance edge, and instr_ready returns in the 4th, giving a throughput of one instruction per 4 cycles.
REQ-028 When instr_valid is held high, the next instruction SHALL be accepted on the first edge back in IDLE, with no bubble beyond REQ-027.

Reset
REQ-029 On reset, the state SHALL be IDLE and the captured fields 0; ula_op=0000, src_b_imm=0, reg_write=0, branch_taken=0, done=0, illegal=0, and instr_ready=1 (IDLE).
REQ-030 Reset asserted in any state SHALL abort the instruction with no done, reg_write or illegal pulse; after deassertion the first edge with instr_valid=1 SHALL be accepted.

Verification
REQ-031 ADD (op 000000, funct 100000) accepted at edge 0 -> ula_op=0010 and src_b_imm=0 in cycle 2; reg_write=done=1 in cycle 3; instr_ready=1 in cycle 4.
REQ-032 ORI (001101) -> ula_op=0001 and src_b_imm=1 in EXECUTE; reg_write pulse in WRITEBACK.
REQ-033 BEQ with zero=1 in EXECUTE -> ula_op=0110; branch_taken=1, done=1, reg_write=0. BNE with zero=1 -> branch_taken=0. BNE with zero=0 -> branch_taken=1.
REQ-034 opcode 111111, and separately R-type funct 001000 -> illegal=done=1 in cycle 2 (ERROR); ula_op stays 0000 throughout; reg_write never asserted.
REQ-035 Reset asserted during EXECUTE of SUB -> outputs return to reset values immediately; no done pulse; the next ADD after release completes normally.
REQ-036 instr_valid held high with opcode/funct changed every cycle -> the fields are captured only at acceptance edges 4 cycles apart, and each ula_op matches the instruction captured at its acceptance edge.
